// File: rtl/sram_bus_arbiter.sv
// Two-way arbiter sharing one sram-like master port between instruction fetch and MEM-stage
// load/store. Registered grant, single outstanding transaction, addr_ok/data_ok handshakes.
module sram_bus_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int DATA_PRIO = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inst_req,
  input  logic [AW-1:0]   inst_addr,
  output logic            inst_addr_ok,
  output logic            inst_data_ok,
  output logic [DW-1:0]   inst_rdata,
  input  logic            data_req,
  input  logic            data_wr,
  input  logic [1:0]      data_size,
  input  logic [DW/8-1:0] data_wstrb,
  input  logic [AW-1:0]   data_addr,
  input  logic [DW-1:0]   data_wdata,
  output logic            data_addr_ok,
  output logic            data_data_ok,
  output logic [DW-1:0]   data_rdata,
  output logic            m_req,
  output logic            m_wr,
  output logic [1:0]      m_size,
  output logic [DW/8-1:0] m_wstrb,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  input  logic            m_addr_ok,
  input  logic            m_data_ok,
  input  logic [DW-1:0]   m_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;  // 1 = data side owns the bus
  logic              last_q, last_d;    // 1 = data side was granted last
  logic              m_wr_q, m_wr_d;
  logic [1:0]        m_size_q, m_size_d;
  logic [DW/8-1:0]   m_wstrb_q, m_wstrb_d;
  logic [AW-1:0]     m_addr_q, m_addr_d;
  logic [DW-1:0]     m_wdata_q, m_wdata_d;
  logic              grant_data, accept, done;

  // On a tie, round-robin hands the bus to whoever was not granted last
  assign grant_data = data_req && (!inst_req || (DATA_PRIO != 0) || !last_q);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b0;
      m_wr_q    <= 1'b0;
      m_size_q  <= '0;
      m_wstrb_q <= '0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      m_wr_q    <= m_wr_d;
      m_size_q  <= m_size_d;
      m_wstrb_q <= m_wstrb_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    m_wr_d    = m_wr_q;
    m_size_d  = m_size_q;
    m_wstrb_d = m_wstrb_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    case (state_q)
      IDLE: begin
        if (inst_req || data_req) begin
          state_d = REQ;
          owner_d = grant_data;
          last_d  = grant_data;
          if (grant_data) begin
            m_wr_d    = data_wr;
            m_size_d  = data_size;
            m_wstrb_d = data_wstrb;
            m_addr_d  = data_addr;
            m_wdata_d = data_wdata;
          end else begin
            m_wr_d    = 1'b0;
            m_size_d  = 2'd2;
            m_wstrb_d = '0;
            m_addr_d  = inst_addr;
            m_wdata_d = '0;
          end
        end
      end
      REQ:     if (m_addr_ok) state_d = WAIT;
      WAIT:    if (m_data_ok) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign accept = (state_q == REQ) && m_addr_ok;
  assign done   = (state_q == WAIT) && m_data_ok;

  assign m_req   = (state_q == REQ);
  assign m_wr    = m_wr_q;
  assign m_size  = m_size_q;
  assign m_wstrb = m_wstrb_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;

  assign inst_addr_ok = accept && !owner_q;
  assign data_addr_ok = accept && owner_q;
  assign inst_data_ok = done && !owner_q;
  assign data_data_ok = done && owner_q;
  assign inst_rdata   = inst_data_ok ? m_rdata : '0;
  assign data_rdata   = data_data_ok ? m_rdata : '0;
endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Bench for sram_bus_arbiter: instance 0 uses data priority, instance 1 round-robin.
// Each round is predicted at transaction level (service order, fields, handshake timing).
module tb_sram_bus_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        inst_req [2];
  logic [31:0] inst_addr [2];
  logic        inst_addr_ok [2];
  logic        inst_data_ok [2];
  logic [31:0] inst_rdata [2];
  logic        data_req [2];
  logic        data_wr [2];
  logic [1:0]  data_size [2];
  logic [3:0]  data_wstrb [2];
  logic [31:0] data_addr [2];
  logic [31:0] data_wdata [2];
  logic        data_addr_ok [2];
  logic        data_data_ok [2];
  logic [31:0] data_rdata [2];
  logic        m_req [2];
  logic        m_wr [2];
  logic [1:0]  m_size [2];
  logic [3:0]  m_wstrb [2];
  logic [31:0] m_addr [2];
  logic [31:0] m_wdata [2];
  logic        m_addr_ok [2];
  logic        m_data_ok [2];
  logic [31:0] m_rdata [2];

  int vec = 0;
  int errs = 0;
  bit lg [2];   // model of last grant: 1 = data

  sram_bus_arbiter #(.AW(32), .DW(32), .DATA_PRIO(1)) u_dut0 (
    .clk(clk), .rst(rst),
    .inst_req(inst_req[0]), .inst_addr(inst_addr[0]), .inst_addr_ok(inst_addr_ok[0]),
    .inst_data_ok(inst_data_ok[0]), .inst_rdata(inst_rdata[0]),
    .data_req(data_req[0]), .data_wr(data_wr[0]), .data_size(data_size[0]),
    .data_wstrb(data_wstrb[0]), .data_addr(data_addr[0]), .data_wdata(data_wdata[0]),
    .data_addr_ok(data_addr_ok[0]), .data_data_ok(data_data_ok[0]), .data_rdata(data_rdata[0]),
    .m_req(m_req[0]), .m_wr(m_wr[0]), .m_size(m_size[0]), .m_wstrb(m_wstrb[0]),
    .m_addr(m_addr[0]), .m_wdata(m_wdata[0]),
    .m_addr_ok(m_addr_ok[0]), .m_data_ok(m_data_ok[0]), .m_rdata(m_rdata[0])
  );

  sram_bus_arbiter #(.AW(32), .DW(32), .DATA_PRIO(0)) u_dut1 (
    .clk(clk), .rst(rst),
    .inst_req(inst_req[1]), .inst_addr(inst_addr[1]), .inst_addr_ok(inst_addr_ok[1]),
    .inst_data_ok(inst_data_ok[1]), .inst_rdata(inst_rdata[1]),
    .data_req(data_req[1]), .data_wr(data_wr[1]), .data_size(data_size[1]),
    .data_wstrb(data_wstrb[1]), .data_addr(data_addr[1]), .data_wdata(data_wdata[1]),
    .data_addr_ok(data_addr_ok[1]), .data_data_ok(data_data_ok[1]), .data_rdata(data_rdata[1]),
    .m_req(m_req[1]), .m_wr(m_wr[1]), .m_size(m_size[1]), .m_wstrb(m_wstrb[1]),
    .m_addr(m_addr[1]), .m_wdata(m_wdata[1]),
    .m_addr_ok(m_addr_ok[1]), .m_data_ok(m_data_ok[1]), .m_rdata(m_rdata[1])
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  // Called just after a negedge with the DUT idle; returns just after a negedge, DUT idle.
  task automatic run_round(input int u, input bit di, input bit dd, input logic [31:0] iaddr,
                           input logic dwr, input logic [1:0] dsize, input logic [3:0] dstrb,
                           input logic [31:0] daddr, input logic [31:0] dwdata,
                           input int stall, input int lat, input logic [31:0] rd, input bit spur);
    int order[$];
    int w, cnt;
    logic [31:0] rdk;
    logic [70:0] exp_f, got_f;
    logic [67:0] exp_o, got_o;
    if (di && dd) begin
      w = (u == 0 || !lg[u]) ? 1 : 0;
      order.push_back(w);
      order.push_back(1 - w);
    end else if (dd) order.push_back(1);
    else if (di) order.push_back(0);
    inst_req[u] = di; inst_addr[u] = iaddr;
    data_req[u] = dd; data_wr[u] = dwr; data_size[u] = dsize; data_wstrb[u] = dstrb;
    data_addr[u] = daddr; data_wdata[u] = dwdata;
    for (int k = 0; k < order.size(); k++) begin
      w = order[k];
      rdk = rd + k;
      if (k > 0) begin
        @(posedge clk); @(negedge clk);
        m_data_ok[u] = spur; m_rdata[u] = $urandom;
        #1;
        vec++;
        got_o = {inst_addr_ok[u], inst_data_ok[u], inst_rdata[u],
                 data_addr_ok[u], data_data_ok[u], data_rdata[u]};
        if (m_req[u] !== 1'b0 || got_o !== 68'h0) begin
          errs++;
          $display("FAIL idle_gap u=%0d: got m_req=%b outs=%h, expected m_req=0 outs=0",
                   u, m_req[u], got_o);
        end
        m_data_ok[u] = 1'b0;
      end
      @(posedge clk); @(negedge clk);
      exp_f = (w == 1) ? {dwr, dsize, dstrb, daddr, dwdata}
                       : {1'b0, 2'd2, 4'h0, iaddr, 32'h0};
      cnt = 0;
      for (int j = 0; j <= stall; j++) begin
        if (j > 0) begin @(posedge clk); @(negedge clk); end
        m_addr_ok[u] = (j == stall);
        m_data_ok[u] = spur && (j < stall);
        m_rdata[u] = $urandom;
        #1;
        if (m_req[u] === 1'b1) cnt++;
        vec++;
        got_f = {m_wr[u], m_size[u], m_wstrb[u], m_addr[u], m_wdata[u]};
        if (got_f !== exp_f) begin
          errs++;
          $display("FAIL req_fields u=%0d k=%0d cyc=%0d: got %h, expected %h", u, k, j, got_f, exp_f);
        end
        vec++;
        exp_o = {(w == 0 && j == stall), 1'b0, 32'h0, (w == 1 && j == stall), 1'b0, 32'h0};
        got_o = {inst_addr_ok[u], inst_data_ok[u], inst_rdata[u],
                 data_addr_ok[u], data_data_ok[u], data_rdata[u]};
        if (got_o !== exp_o) begin
          errs++;
          $display("FAIL req_outs u=%0d k=%0d cyc=%0d: got %h, expected %h", u, k, j, got_o, exp_o);
        end
      end
      vec++;
      if (cnt !== stall + 1) begin
        errs++;
        $display("FAIL m_req_cycles u=%0d k=%0d: got %0d, expected %0d", u, k, cnt, stall + 1);
      end
      @(posedge clk); @(negedge clk);
      m_addr_ok[u] = 1'b0;
      if (w == 1) data_req[u] = 1'b0; else inst_req[u] = 1'b0;
      for (int j = 1; j <= lat; j++) begin
        if (j > 1) begin @(posedge clk); @(negedge clk); end
        m_data_ok[u] = (j == lat);
        m_rdata[u] = (j == lat) ? rdk : $urandom;
        #1;
        vec++;
        exp_o = {1'b0, (w == 0 && j == lat), (w == 0 && j == lat) ? rdk : 32'h0,
                 1'b0, (w == 1 && j == lat), (w == 1 && j == lat) ? rdk : 32'h0};
        got_o = {inst_addr_ok[u], inst_data_ok[u], inst_rdata[u],
                 data_addr_ok[u], data_data_ok[u], data_rdata[u]};
        if (m_req[u] !== 1'b0 || got_o !== exp_o) begin
          errs++;
          $display("FAIL wait_outs u=%0d k=%0d cyc=%0d: got m_req=%b %h, expected m_req=0 %h",
                   u, k, j, m_req[u], got_o, exp_o);
        end
      end
      lg[u] = (w == 1);
    end
    @(posedge clk); @(negedge clk);
    m_data_ok[u] = 1'b0;
    m_rdata[u] = 32'h0;
  endtask

  task automatic test_reset();
    logic [70:0] got_f;
    logic [67:0] got_o;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      #1;
      vec++;
      got_f = {m_wr[u], m_size[u], m_wstrb[u], m_addr[u], m_wdata[u]};
      got_o = {inst_addr_ok[u], inst_data_ok[u], inst_rdata[u],
               data_addr_ok[u], data_data_ok[u], data_rdata[u]};
      if (m_req[u] !== 1'b0 || got_f !== 71'h0 || got_o !== 68'h0) begin
        errs++;
        $display("FAIL reset_state u=%0d: got m_req=%b f=%h o=%h, expected all 0",
                 u, m_req[u], got_f, got_o);
      end
    end
    rst = 1'b1;
    lg[0] = 1'b0; lg[1] = 1'b0;
  endtask

  task automatic test_inst_read();
    for (int u = 0; u < 2; u++)
      run_round(u, 1, 0, 32'hBFC00000, 1'b0, 2'd0, 4'h0, 32'h0, 32'h0, 0, 2, 32'h3C1DBFC0, 0);
  endtask

  task automatic test_data_priority();
    run_round(0, 1, 1, 32'hBFC00004, 1'b1, 2'd2, 4'hF, 32'h80001000, 32'hDEADBEEF,
              0, 1, 32'h12345678, 0);
  endtask

  task automatic test_round_robin();
    for (int r = 0; r < 2; r++)
      run_round(1, 1, 1, 32'hBFC00100 + r * 8, 1'b1, 2'd2, 4'hF, 32'h80002000 + r * 4,
                32'hCAFE0000 + r, 0, 1, 32'hA0A00000 + r, 0);
  endtask

  task automatic test_stall();
    for (int u = 0; u < 2; u++)
      run_round(u, 0, 1, 32'h0, 1'b0, 2'd0, 4'h0, 32'h80000013, 32'h0, 5, 3, 32'h000000FF, 0);
  endtask

  task automatic test_reset_mid();
    logic [67:0] got_o;
    for (int u = 0; u < 2; u++) begin
      data_req[u] = 1'b1; data_wr[u] = 1'b0; data_size[u] = 2'd2; data_wstrb[u] = 4'h0;
      data_addr[u] = $urandom; data_wdata[u] = $urandom;
      @(posedge clk); @(negedge clk);
      m_addr_ok[u] = 1'b1;
      #1;
      vec++;
      if (data_addr_ok[u] !== 1'b1) begin
        errs++;
        $display("FAIL rst_mid_accept u=%0d: got %b, expected 1", u, data_addr_ok[u]);
      end
      @(posedge clk); @(negedge clk);
      m_addr_ok[u] = 1'b0; data_req[u] = 1'b0;
      rst = 1'b0;
      @(posedge clk); @(negedge clk);
      rst = 1'b1;
      lg[0] = 1'b0; lg[1] = 1'b0;
      #1;
      vec++;
      if (m_req[u] !== 1'b0 || m_addr[u] !== 32'h0) begin
        errs++;
        $display("FAIL rst_mid_state u=%0d: got m_req=%b m_addr=%h, expected 0 0",
                 u, m_req[u], m_addr[u]);
      end
      @(posedge clk); @(negedge clk);
      m_data_ok[u] = 1'b1; m_rdata[u] = 32'h55AA55AA;
      #1;
      vec++;
      got_o = {inst_addr_ok[u], inst_data_ok[u], inst_rdata[u],
               data_addr_ok[u], data_data_ok[u], data_rdata[u]};
      if (got_o !== 68'h0) begin
        errs++;
        $display("FAIL rst_late_data_ok u=%0d: got %h, expected 0", u, got_o);
      end
      @(posedge clk); @(negedge clk);
      m_data_ok[u] = 1'b0; m_rdata[u] = 32'h0;
      run_round(u, 0, 1, 32'h0, 1'b1, 2'd1, 4'h3, 32'h80000400, $urandom, 1, 1, 32'h0BAD0001, 0);
    end
  endtask

  task automatic test_spurious();
    logic [67:0] got_o;
    for (int u = 0; u < 2; u++) begin
      for (int c = 0; c < 3; c++) begin
        m_data_ok[u] = 1'b1; m_rdata[u] = $urandom;
        #1;
        vec++;
        got_o = {inst_addr_ok[u], inst_data_ok[u], inst_rdata[u],
                 data_addr_ok[u], data_data_ok[u], data_rdata[u]};
        if (m_req[u] !== 1'b0 || got_o !== 68'h0) begin
          errs++;
          $display("FAIL spurious_idle u=%0d: got m_req=%b %h, expected 0 0", u, m_req[u], got_o);
        end
        @(posedge clk); @(negedge clk);
      end
      m_data_ok[u] = 1'b0;
      run_round(u, 1, 0, 32'hBFC00200, 1'b0, 2'd0, 4'h0, 32'h0, 32'h0, 3, 2, 32'h77777777, 1);
    end
  endtask

  task automatic test_random();
    bit di, dd;
    int sel;
    for (int u = 0; u < 2; u++) begin
      for (int r = 0; r < 20; r++) begin
        sel = $urandom_range(2, 0);
        di = (sel != 1);
        dd = (sel != 0);
        run_round(u, di, dd, $urandom, 1'($urandom), 2'($urandom_range(2, 0)), 4'($urandom),
                  $urandom, $urandom, $urandom_range(3, 0), $urandom_range(3, 1), $urandom,
                  1'($urandom));
      end
    end
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      inst_req[u] = 1'b0; inst_addr[u] = '0;
      data_req[u] = 1'b0; data_wr[u] = 1'b0; data_size[u] = '0; data_wstrb[u] = '0;
      data_addr[u] = '0; data_wdata[u] = '0;
      m_addr_ok[u] = 1'b0; m_data_ok[u] = 1'b0; m_rdata[u] = '0;
    end
    test_reset();
    test_inst_read();
    test_data_priority();
    test_round_robin();
    test_stall();
    test_reset_mid();
    test_spurious();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
